// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: evaluates branch/set conditions from ALU flags, checks
// the actual direction against the fetch-time prediction, registers the result
// with a fetch redirect, and keeps a PC-indexed table of 2-bit counters.
module branch_resolve_unit #(
    parameter int         PC_W     = 16,
    parameter int         IDX_W    = 6,
    parameter int         CNT_W    = 16,
    parameter logic [1:0] INIT_CTR = 2'b01,
    parameter bit         USE_OF   = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PC_W-1:0]  f_pc,
    output logic             f_pred_taken,
    input  logic             ex_valid,
    input  logic [2:0]       ex_branch,
    input  logic             ex_is_set,
    input  logic [PC_W-1:0]  ex_pc,
    input  logic             ex_pred_taken,
    input  logic [PC_W-1:0]  ex_target,
    input  logic [PC_W-1:0]  ex_pc_plus2,
    input  logic             SF,
    input  logic             ZF,
    input  logic             OF,
    input  logic             CF,
    input  logic             flush,
    output logic             res_valid,
    output logic             res_taken,
    output logic             res_setval,
    output logic             res_mispredict,
    output logic [PC_W-1:0]  res_redirect_pc,
    output logic [CNT_W-1:0] mispredict_cnt
);

    localparam int ENTRIES = 1 << IDX_W;

    logic [1:0]       pht [ENTRIES];
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic             cond;
    logic             accept;
    logic             is_br;
    logic             taken_nx;
    logic             setval_nx;
    logic             mis_nx;
    logic [PC_W-1:0]  redirect_nx;
    logic             pht_wr;
    logic             unused_bits;

    // Saturating 2-bit counter step toward the resolved direction.
    function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic up);
        if (up)
            return (ctr == 2'b11) ? ctr : ctr + 2'd1;
        else
            return (ctr == 2'b00) ? ctr : ctr - 2'd1;
    endfunction

    // Instructions are halfword aligned, so bit 0 never selects an entry.
    assign rd_idx       = f_pc[IDX_W:1];
    assign wr_idx       = ex_pc[IDX_W:1];
    assign f_pred_taken = pht[rd_idx][1];
    assign unused_bits  = ^{f_pc, ex_pc};

    // Condition decode from the flags; signed mode folds overflow into LT/GE.
    always_comb begin
        cond = 1'b0;
        case (ex_branch)
            3'd1:    cond = 1'b1;
            3'd2:    cond = ZF;
            3'd3:    cond = ~ZF;
            3'd4:    cond = USE_OF ? (SF ^ OF) : SF;
            3'd5:    cond = USE_OF ? ~(SF ^ OF) : (~SF | ZF);
            3'd6:    cond = CF;
            default: cond = 1'b0;
        endcase
    end

    // Next-state of the resolve stage; BSCO only means something as a set op.
    always_comb begin
        accept      = ex_valid & ~flush;
        is_br       = (ex_branch >= 3'd1) && (ex_branch <= 3'd5);
        taken_nx    = ~ex_is_set & is_br & cond;
        setval_nx   = ex_is_set & cond;
        mis_nx      = accept & ~ex_is_set & is_br & (taken_nx != ex_pred_taken);
        redirect_nx = taken_nx ? ex_target : ex_pc_plus2;
        pht_wr      = accept & ~ex_is_set & (ex_branch >= 3'd2) && (ex_branch <= 3'd5);
    end

    // Resolve stage register: results live for exactly one cycle after accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid       <= 1'b0;
            res_taken       <= 1'b0;
            res_setval      <= 1'b0;
            res_mispredict  <= 1'b0;
            res_redirect_pc <= '0;
        end else if (accept) begin
            res_valid       <= 1'b1;
            res_taken       <= taken_nx;
            res_setval      <= setval_nx;
            res_mispredict  <= mis_nx;
            res_redirect_pc <= redirect_nx;
        end else begin
            res_valid       <= 1'b0;
            res_taken       <= 1'b0;
            res_setval      <= 1'b0;
            res_mispredict  <= 1'b0;
            res_redirect_pc <= '0;
        end
    end

    // Pattern history table; conditional branches train it, JUMP does not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++)
                pht[i] <= INIT_CTR;
        end else if (pht_wr) begin
            pht[wr_idx] <= ctr_step(pht[wr_idx], cond);
        end
    end

    // Mispredict counter, sticks at all ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mispredict_cnt <= '0;
        else if (mis_nx && (mispredict_cnt != '1))
            mispredict_cnt <= mispredict_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: one default instance and one with signed
// compare and a 2-bit mispredict counter, both fed the same stimulus.
module tb_branch_resolve_unit;

    typedef struct {
        logic        v;
        logic        t;
        logic        s;
        logic        m;
        logic [15:0] rpc;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] f_pc;
    logic        ex_valid, ex_is_set, ex_pred_taken, flush;
    logic [2:0]  ex_branch;
    logic [15:0] ex_pc, ex_target, ex_pc_plus2;
    logic        SF, ZF, OF, CF;

    logic        fp0, rv0, rt0, rs0, rm0;
    logic [15:0] rpc0, cnt0;
    logic        fp1, rv1, rt1, rs1, rm1;
    logic [15:0] rpc1;
    logic [1:0]  cnt1;

    int   checks = 0;
    int   failures = 0;
    res_t sb[$];
    logic [1:0] mpht [2][64];
    int   mcnt [2];
    int   cmax [2] = '{65535, 3};

    always #5 clk = ~clk;

    branch_resolve_unit dut0 (
        .clk(clk), .rst_n(rst_n), .f_pc(f_pc), .f_pred_taken(fp0),
        .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_is_set(ex_is_set),
        .ex_pc(ex_pc), .ex_pred_taken(ex_pred_taken), .ex_target(ex_target),
        .ex_pc_plus2(ex_pc_plus2), .SF(SF), .ZF(ZF), .OF(OF), .CF(CF),
        .flush(flush), .res_valid(rv0), .res_taken(rt0), .res_setval(rs0),
        .res_mispredict(rm0), .res_redirect_pc(rpc0), .mispredict_cnt(cnt0)
    );

    branch_resolve_unit #(.CNT_W(2), .USE_OF(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .f_pc(f_pc), .f_pred_taken(fp1),
        .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_is_set(ex_is_set),
        .ex_pc(ex_pc), .ex_pred_taken(ex_pred_taken), .ex_target(ex_target),
        .ex_pc_plus2(ex_pc_plus2), .SF(SF), .ZF(ZF), .OF(OF), .CF(CF),
        .flush(flush), .res_valid(rv1), .res_taken(rt1), .res_setval(rs1),
        .res_mispredict(rm1), .res_redirect_pc(rpc1), .mispredict_cnt(cnt1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic mcond(input logic [2:0] code, input logic sf, input logic zf,
                                   input logic of, input logic cf, input bit use_of);
        case (code)
            3'd1:    return 1'b1;
            3'd2:    return zf;
            3'd3:    return !zf;
            3'd4:    return use_of ? (sf ^ of) : sf;
            3'd5:    return use_of ? !(sf ^ of) : (!sf || zf);
            3'd6:    return cf;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mcnt[d] = 0;
            for (int i = 0; i < 64; i++) mpht[d][i] = 2'b01;
        end
        sb.delete();
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".v0"}, rv0, 0);   chk({tag, ".v1"}, rv1, 0);
        chk({tag, ".t0"}, rt0, 0);   chk({tag, ".s0"}, rs0, 0);
        chk({tag, ".m0"}, rm0, 0);   chk({tag, ".m1"}, rm1, 0);
        chk({tag, ".pc0"}, rpc0, 0); chk({tag, ".pc1"}, rpc1, 0);
        chk({tag, ".c0"}, cnt0, 0);  chk({tag, ".c1"}, cnt1, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        ex_valid = 1'b0;
        flush = 1'b0;
        #1;
        model_reset();
        chk_idle("rst");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic issue(input string tag, input logic [2:0] code, input logic set,
                         input logic [15:0] pc, input logic pred, input logic [15:0] tgt,
                         input logic sf, input logic zf, input logic of, input logic cf,
                         input logic vld, input logic fl);
        res_t e;
        logic c, br;
        logic [5:0] idx;
        @(negedge clk);
        ex_valid = vld; flush = fl; ex_branch = code; ex_is_set = set;
        ex_pc = pc; f_pc = pc; ex_pred_taken = pred; ex_target = tgt;
        ex_pc_plus2 = pc + 16'd2;
        SF = sf; ZF = zf; OF = of; CF = cf;
        idx = pc[6:1];
        #1;
        chk({tag, ".pre0"}, fp0, mpht[0][idx][1]);
        chk({tag, ".pre1"}, fp1, mpht[1][idx][1]);
        for (int d = 0; d < 2; d++) begin
            c = mcond(code, sf, zf, of, cf, d == 1);
            br = (code >= 3'd1) && (code <= 3'd5);
            e = '{v: 1'b0, t: 1'b0, s: 1'b0, m: 1'b0, rpc: 16'h0};
            if (vld && !fl) begin
                e.v = 1'b1;
                if (set) begin
                    e.s = c;
                end else begin
                    e.t = br && c;
                    e.m = br && (e.t != pred);
                    if (code >= 3'd2 && code <= 3'd5) begin
                        if (c && mpht[d][idx] != 2'b11) mpht[d][idx] = mpht[d][idx] + 2'd1;
                        if (!c && mpht[d][idx] != 2'b00) mpht[d][idx] = mpht[d][idx] - 2'd1;
                    end
                end
                e.rpc = e.t ? tgt : pc + 16'd2;
                if (e.m && mcnt[d] < cmax[d]) mcnt[d]++;
            end
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
        flush = 1'b0;
        e = sb.pop_front();
        chk({tag, ".v0"}, rv0, e.v);  chk({tag, ".t0"}, rt0, e.t);
        chk({tag, ".s0"}, rs0, e.s);  chk({tag, ".m0"}, rm0, e.m);
        chk({tag, ".pc0"}, rpc0, e.rpc);
        e = sb.pop_front();
        chk({tag, ".v1"}, rv1, e.v);  chk({tag, ".t1"}, rt1, e.t);
        chk({tag, ".s1"}, rs1, e.s);  chk({tag, ".m1"}, rm1, e.m);
        chk({tag, ".pc1"}, rpc1, e.rpc);
        chk({tag, ".c0"}, cnt0, mcnt[0]);
        chk({tag, ".c1"}, cnt1, mcnt[1]);
        chk({tag, ".post0"}, fp0, mpht[0][idx][1]);
        chk({tag, ".post1"}, fp1, mpht[1][idx][1]);
    endtask

    initial begin
        int seq [5] = '{1, 2, 3, 3, 3};
        int fseq [5] = '{0, 1, 1, 1, 0};
        rst_n = 1'b0; f_pc = '0; ex_valid = 1'b0; flush = 1'b0; ex_branch = '0;
        ex_is_set = 1'b0; ex_pc = '0; ex_pred_taken = 1'b0; ex_target = '0;
        ex_pc_plus2 = '0; SF = 0; ZF = 0; OF = 0; CF = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_idle("init");
        for (int i = 0; i < 64; i++) begin
            f_pc = 16'(i * 2);
            #1;
            chk("init.pht0", fp0, 0);
            chk("init.pht1", fp1, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // BEQZ taken against not-taken prediction
        issue("beqz", 3'd2, 0, 16'h0010, 0, 16'h0040, 0, 1, 0, 0, 1, 0);
        chk("beqz.taken", rt0, 1); chk("beqz.mis", rm0, 1);
        chk("beqz.rpc", rpc0, 16'h0040); chk("beqz.cnt", cnt0, 1);
        chk("beqz.pht8", fp0, 1);

        // BNEZ counter walk 01->10->11->10->01
        do_reset();
        f_pc = 16'h0010;
        #1;
        chk("walk.f0", fp0, fseq[0]);
        for (int i = 0; i < 4; i++) begin
            issue("bnez", 3'd3, 0, 16'h0010, 1, 16'h0080, 0, (i >= 2), 0, 0, 1, 0);
            chk("walk.f", fp0, fseq[i + 1]);
        end

        // Set-type BLTZ: legacy vs signed compare, no table write
        do_reset();
        issue("setlt", 3'd4, 1, 16'h0020, 0, 16'h0100, 1, 0, 1, 0, 1, 0);
        chk("setlt.s0", rs0, 1); chk("setlt.s1", rs1, 0);
        chk("setlt.t0", rt0, 0); chk("setlt.f", fp0, 0);

        // Flushed mispredicting BEQZ has no effect
        issue("flush", 3'd2, 0, 16'h0010, 0, 16'h0040, 0, 1, 0, 0, 1, 1);
        chk("flush.v", rv0, 0); chk("flush.cnt", cnt0, 0); chk("flush.f", fp0, 0);

        // Counter saturation on the 2-bit instance
        for (int i = 0; i < 5; i++) begin
            issue("sat", 3'd1, 0, 16'h0030, 0, 16'h0200, 0, 0, 0, 0, 1, 0);
            chk("sat.cnt2", cnt1, seq[i]);
        end

        // Reset asserted while a result is being presented
        issue("pend", 3'd2, 0, 16'h0010, 0, 16'h0044, 0, 1, 0, 0, 1, 0);
        rst_n = 1'b0;
        #1;
        chk_idle("midrst");
        f_pc = 16'h0010;
        #1;
        chk("midrst.f", fp0, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Random mix over a few colliding table entries
        for (int i = 0; i < 60; i++) begin
            issue("rnd", 3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) == 0),
                  16'($urandom_range(0, 7) * 2 + 16'h0100 * $urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 16'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 9) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
